// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and the microcoded controller it feeds.
// The halt opcode here only takes effect in builds with FETCH_HALT_EN defined.
package cpu_pkg;

  localparam int CPU_IR_W = 16;
  localparam int CPU_PC_W = 8;
  localparam logic [3:0] CPU_HALT_OPCODE = 4'hF;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  function automatic logic is_halt(input logic [CPU_IR_W-1:0] ir, input logic [3:0] opc);
    return ir[CPU_IR_W-1 -: 4] == opc;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous reset, then load, then modulo increment.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int PC_W = CPU_PC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] load_value,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset)
      pc <= '0;
    else if (load)
      pc <= load_value;
    else if (inc)
      pc <= pc + 1'b1;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues reads to the synchronous instruction memory and captures IR.
// Optional halt-on-opcode support is compiled in with FETCH_HALT_EN.
//
// state  | meaning
// IDLE   | waiting for fetch_req
// ISSUE  | imem_en high, memory samples imem_addr at the next edge
// WAIT   | latency countdown; capture into IR when the counter is 1
// HALTED | halt opcode captured, only reset exits (FETCH_HALT_EN only)
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int         PC_W         = CPU_PC_W,
  parameter int         IR_W         = CPU_IR_W,
  parameter int         IMEM_LATENCY = 1,
  parameter logic [3:0] HALT_OPCODE  = CPU_HALT_OPCODE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_value,
  input  logic [IR_W-1:0] imem_rdata,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  output logic [IR_W-1:0] IR,
  output logic            fetch_done,
  output logic            busy,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [1:0] state;
  logic [2:0] lat_cnt;
  logic       redirect;
  logic       capture;
  logic       halt_hit;
  logic       pc_load_en;
  logic       pc_inc;

  assign capture    = (state == ST_WAIT) && (lat_cnt == 3'd1);
  assign halt_hit   = HALT_EN && capture && is_halt(imem_rdata, HALT_OPCODE);
  assign pc_load_en = pc_load && (state != ST_HALTED);
  // A redirect during the fetch leaves the target in place instead of stepping past it.
  assign pc_inc     = capture && !redirect && !halt_hit;

  fetch_pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (pc_load_en),
    .load_value (pc_load_value),
    .inc        (pc_inc),
    .pc         (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= 3'd0;
      redirect   <= 1'b0;
      imem_en    <= 1'b0;
      imem_addr  <= '0;
      IR         <= '0;
      fetch_done <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      if (pc_load_en && busy)
        redirect <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (fetch_req) begin
            imem_en   <= 1'b1;
            imem_addr <= pc;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          imem_en <= 1'b0;
          lat_cnt <= 3'(IMEM_LATENCY);
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (capture) begin
            IR         <= imem_rdata;
            fetch_done <= 1'b1;
            busy       <= 1'b0;
            redirect   <= 1'b0;
            halted     <= halt_hit;
            state      <= halt_hit ? ST_HALTED : ST_IDLE;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (memory latency 1 and 3) share stimulus and
// are checked every cycle against a transaction-level model plus directed literal checks.
module tb_instr_fetch_unit;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic        pc_load;
  logic [7:0]  pc_load_value;

  logic        en_o     [2];
  logic [7:0]  addr_o   [2];
  logic [15:0] ir_o     [2];
  logic        done_o   [2];
  logic        busy_o   [2];
  logic [7:0]  pc_o     [2];
  logic        halted_o [2];
  logic [15:0] rdata_i  [2];

  logic [15:0] mem  [256];
  logic [15:0] pipe [2][4];

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.IMEM_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .imem_rdata(rdata_i[0]), .imem_en(en_o[0]),
    .imem_addr(addr_o[0]), .IR(ir_o[0]), .fetch_done(done_o[0]), .busy(busy_o[0]),
    .pc(pc_o[0]), .halted(halted_o[0])
  );

  instr_fetch_unit #(.IMEM_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .imem_rdata(rdata_i[1]), .imem_en(en_o[1]),
    .imem_addr(addr_o[1]), .IR(ir_o[1]), .fetch_done(done_o[1]), .busy(busy_o[1]),
    .pc(pc_o[1]), .halted(halted_o[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Memory: data is valid for exactly one cycle, LAT edges after the enabled sample; junk otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 3; j > 0; j--) pipe[i][j] <= pipe[i][j-1];
      pipe[i][0] <= en_o[i] ? mem[addr_o[i]] : 16'($urandom);
    end
  end
  assign rdata_i[0] = pipe[0][0];
  assign rdata_i[1] = pipe[1][2];

  // Transaction-level model: a fetch occupies LAT+1 edges after acceptance, then captures mem[addr].
  logic [7:0]  m_pc    [2];
  logic [7:0]  m_addr  [2];
  logic [15:0] m_ir    [2];
  logic        m_en    [2];
  logic        m_done  [2];
  logic        m_busy  [2];
  logic        m_halt  [2];
  logic        m_redir [2];
  int          m_left  [2];

  always @(posedge clk) begin
    logic [15:0] word;
    logic        hit;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pc[i] = 8'h00; m_addr[i] = 8'h00; m_ir[i] = 16'h0000; m_en[i] = 1'b0;
        m_done[i] = 1'b0; m_busy[i] = 1'b0; m_halt[i] = 1'b0; m_redir[i] = 1'b0; m_left[i] = 0;
      end else begin
        m_en[i] = 1'b0;
        m_done[i] = 1'b0;
        if (!m_halt[i]) begin
          if (!m_busy[i]) begin
            if (fetch_req) begin
              m_en[i] = 1'b1; m_addr[i] = m_pc[i]; m_busy[i] = 1'b1; m_left[i] = lat_of(i) + 1;
            end
            if (pc_load) m_pc[i] = pc_load_value;
          end else begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
              word = mem[m_addr[i]];
              hit = HALT_EN && (word[15:12] == 4'hF);
              m_ir[i] = word; m_done[i] = 1'b1; m_busy[i] = 1'b0;
              if (pc_load) m_pc[i] = pc_load_value;
              else if (!m_redir[i] && !hit) m_pc[i] = m_pc[i] + 8'd1;
              m_redir[i] = 1'b0;
              m_halt[i] = hit;
            end else if (pc_load) begin
              m_pc[i] = pc_load_value;
              m_redir[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        check("imem_en", i, 32'(en_o[i]), 32'(m_en[i]));
        check("imem_addr", i, 32'(addr_o[i]), 32'(m_addr[i]));
        check("IR", i, 32'(ir_o[i]), 32'(m_ir[i]));
        check("fetch_done", i, 32'(done_o[i]), 32'(m_done[i]));
        check("busy", i, 32'(busy_o[i]), 32'(m_busy[i]));
        check("pc", i, 32'(pc_o[i]), 32'(m_pc[i]));
        check("halted", i, 32'(halted_o[i]), 32'(m_halt[i]));
      end
    end
  end

  task automatic load_pc(input logic [7:0] v);
    pc_load = 1'b1; pc_load_value = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  initial begin
    logic pl;
    reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_load_value = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom) & 16'h7FFF;
    mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456;
    mem[5] = 16'h5555; mem[255] = 16'hBEEF;
    @(negedge clk);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_pc", 0, 32'(pc_o[0]), 32'h0);
    check("rst_ir", 1, 32'(ir_o[1]), 32'h0);

    // Held fetch_req from pc=0: latency 1 takes 3 edges per fetch, latency 3 takes 5.
    fetch_req = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("t1_en", 0, 32'(en_o[0]), 32'h1);
        check("t1_addr", 0, 32'(addr_o[0]), 32'h0);
      end
      if (n == 2) check("t1_en_drop", 0, 32'(en_o[0]), 32'h0);
      if (n == 3) begin
        check("t1_ir", 0, 32'(ir_o[0]), 32'h1234);
        check("t1_done", 0, 32'(done_o[0]), 32'h1);
        check("t1_pc", 0, 32'(pc_o[0]), 32'h1);
      end
      if (n == 4) check("t1_done_pulse", 0, 32'(done_o[0]), 32'h0);
      if (n == 5) check("t2_ir_a", 1, 32'(ir_o[1]), 32'h1234);
      if (n == 10) check("t2_ir_b", 1, 32'(ir_o[1]), 32'h2345);
      if (n == 15) begin
        check("t2_ir_c", 1, 32'(ir_o[1]), 32'h3456);
        check("t2_pc", 1, 32'(pc_o[1]), 32'h3);
      end
      if ((n % 5) != 0) check("t2_busy", 1, 32'(busy_o[1]), 32'h1);
    end
    fetch_req = 1'b0;
    @(negedge clk);

    // Redirect during WAIT: in-flight fetch keeps old address, no increment afterwards.
    load_pc(8'h05);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    load_pc(8'h40);
    repeat (2) @(negedge clk);
    check("t3_ir", 1, 32'(ir_o[1]), 32'h5555);
    check("t3_pc", 1, 32'(pc_o[1]), 32'h40);
    check("t3_pc", 0, 32'(pc_o[0]), 32'h40);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    check("t3_next_addr", 1, 32'(addr_o[1]), 32'h40);
    check("t3_next_en", 1, 32'(en_o[1]), 32'h1);
    repeat (5) @(negedge clk);

    // PC wrap at 8'hFF.
    load_pc(8'hFF);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_ir", 1, 32'(ir_o[1]), 32'hBEEF);
    check("t4_pc", 1, 32'(pc_o[1]), 32'h0);
    check("t4_pc", 0, 32'(pc_o[0]), 32'h0);

    // Reset while the latency-3 fetch is in WAIT.
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_ir", 1, 32'(ir_o[1]), 32'h0);
    check("t5_busy", 1, 32'(busy_o[1]), 32'h0);
    check("t5_pc", 1, 32'(pc_o[1]), 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_no_done", 1, 32'(done_o[1]), 32'h0);
    end

    // Halt opcode at address 3.
    mem[3] = 16'hF000;
    load_pc(8'h03);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_ir", 1, 32'(ir_o[1]), 32'hF000);
    check("t6_halted", 1, 32'(halted_o[1]), HALT_EN ? 32'h1 : 32'h0);
    check("t6_pc", 1, 32'(pc_o[1]), HALT_EN ? 32'h3 : 32'h4);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    check("t6_req_en", 1, 32'(en_o[1]), HALT_EN ? 32'h0 : 32'h1);
    repeat (5) @(negedge clk);
    load_pc(8'h20);
    check("t6_load", 1, 32'(pc_o[1]), HALT_EN ? 32'h3 : 32'h20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_halt_clr", 1, 32'(halted_o[1]), 32'h0);

    // Randomized traffic with occasional resets, redirects and wrap targets.
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      fetch_req = ($urandom_range(0, 99) < 60);
      pl = ($urandom_range(0, 99) < 15);
      if (pl && fetch_req && !(m_busy[0] && m_busy[1])) pl = 1'b0;
      pc_load = pl;
      pc_load_value = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; fetch_req = 1'b0; pc_load = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the microcoded controller.
- Owns the program counter and issues reads to the synchronous instruction memory.
- Captures the returned word into the 16-bit IR that drives the controller's mapping block.
- Fetches are requested by a controller OPs bit (fetch_req). PC redirects come from the controller/datapath (pc_load).

Parameters:
- PC_W, 8, program counter / instruction memory address width.
- IR_W, 16, instruction width. Fixed to match controller IR.
- IMEM_LATENCY, 1, edges from the memory sampling the address to rdata valid (1..4).
- HALT_OPCODE, 4'hF, IR[15:12] value treated as halt. Used only with FETCH_HALT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  controller request to fetch the next instruction (level, sampled each edge).
- pc_load  in  1  load PC from pc_load_value.
- pc_load_value  in  PC_W  jump/branch target.
- imem_rdata  in  IR_W  instruction memory read data.
- imem_en  out  1  memory read enable, one-cycle pulse per fetch.
- imem_addr  out  PC_W  memory address, registered.
- IR  out  IR_W  instruction register to controller.
- fetch_done  out  1  one-cycle pulse: IR updated this cycle.
- busy  out  1  fetch in flight.
- pc  out  PC_W  current program counter.
- halted  out  1  halt reached (FETCH_HALT_EN only, else constant 0).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset. All state changes on the rising edge of clk.
- Reset values: pc=0, IR=0, imem_addr=0, imem_en=0, fetch_done=0, busy=0, halted=0, state=IDLE, latency counter=0, redirect flag=0.
- States: IDLE, ISSUE, WAIT, HALTED (HALTED only with the macro).
- IDLE:
  - fetch_req=1 at edge k → imem_en=1, imem_addr=pc, busy=1, state=ISSUE.
  - fetch_req=0 → hold.
- ISSUE (memory samples address at edge k+1): imem_en←0, counter←IMEM_LATENCY, state=WAIT.
- WAIT: counter decrements each edge. At the edge where the counter is 1:
  - IR←imem_rdata, fetch_done←1 for one cycle, busy←0, state=IDLE.
  - pc←pc+1, unless the redirect flag is set.
  - Result: IR is updated at edge k+1+IMEM_LATENCY; fetch_done is high in the following cycle.
- fetch_req while busy=1 is ignored; no queuing. The controller holds fetch_req until fetch_done.
- fetch_req at the same edge as fetch_done's assertion: not accepted (state still WAIT). It is accepted at the next edge if still high.
- pc_load:
  - Applied at any edge in any state except HALTED: pc←pc_load_value.
  - If busy, sets the redirect flag. The in-flight fetch completes with the old address, and the capture-edge increment is suppressed.
  - Flag clears on capture.
  - pc_load at the capture edge itself also wins over the increment.
- PC arithmetic is modulo 2^PC_W: pc=2^PC_W-1 increments to 0, and no flag is raised.
- IR holds its value between fetches. imem_rdata is ignored outside the capture edge.
- Reset mid-fetch aborts the fetch. Data returning afterwards is ignored, and there is no fetch_done pulse.

Optional Feature:
- Macro FETCH_HALT_EN.
- Defined:
  - On capture, if imem_rdata[15:12]==HALT_OPCODE then IR is still loaded and fetch_done still pulses.
  - pc is not incremented. state=HALTED and halted=1.
  - In HALTED, fetch_req and pc_load are ignored. Only reset exits.
- Undefined:
  - No HALTED state. HALT_OPCODE is an ordinary instruction.
  - halted is tied to 0.

Decomposition:
- Shared package (cpu_pkg) holds:
  - IR_W=16 and the default PC_W.
  - HALT_OPCODE.
  - fetch state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, HALTED=2'd3.
- One sub-module: fetch_pc_reg.
  - Handles PC_W-wide reset, load and increment.
  - Priority: reset > load > increment.
  - The FSM and latency counter stay in the top module.

Test Plan:
- Reset, then fetch_req=1 with IMEM_LATENCY=1 and mem[0]=16'h1234 → imem_en pulses one cycle with addr 0. IR=16'h1234 two edges after the request edge; fetch_done pulses once; pc=1.
- IMEM_LATENCY=3, back-to-back held fetch_req from pc=0 with mem[0..2]=A,B,C → IR sequence A,B,C. Each fetch takes 5 edges; busy never drops between issue and capture.
- pc_load=1 with value 8'h40 during WAIT of the fetch at pc=5 → IR gets mem[5]. After capture pc=8'h40, not 6. The next fetch reads address 8'h40.
- pc=8'hFF, fetch → IR=mem[255]; pc wraps to 0.
- Reset asserted in WAIT → the next cycle shows all outputs at reset values. No fetch_done even when rdata returns.
- FETCH_HALT_EN, mem[3]=16'hF000 → after fetching address 3, halted=1 and pc=3. Further fetch_req and pc_load produce no imem_en; reset clears halted.
